truth_table_sweeper: RTL and testbench

Sequential characterization stage that drives a 3-input combinational logic gate (a truth-table block with inputs `in1`, `in2`, `in3` and output `out`). It steps the gate through all eight input combinations, waits a settle interval per row, and majority-votes several samples of the gate output. It then assembles the 8-bit truth-table word (row 000 in the MSB, the same hex encoding the gate library uses) and compares it against an expected value. It sits directly upstream and downstream of the gate under test: it feeds the gate's inputs and consumes its output.

---
 rtl/truth_table_sweeper.sv | 117 +++++++++++
 tb/tb_truth_table_sweeper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through all eight input rows, majority-votes its output per row,
// and publishes the resulting 8-bit truth-table word (row 000 in the MSB).
module truth_table_sweeper #(
   parameter int           SETTLE_CYCLES = 4,
   parameter int           SAMPLES       = 3,
   parameter logic [7:0]   EXPECTED      = 8'h87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       match
);

   localparam int            OW       = $clog2(SAMPLES + 1);
   localparam logic [7:0]    SET_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0]    SMP_LAST = 8'(SAMPLES - 1);
   localparam logic [OW-1:0] HALF     = OW'(SAMPLES / 2);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t        state;
   logic [2:0]    row;
   logic [7:0]    cnt;
   logic [OW-1:0] ones;
   logic [7:0]    shadow;
   logic [OW-1:0] ones_nx;
   logic [7:0]    shadow_nx;

   // Vote includes the current cycle's sample; row r lands in bit 7-r (== ~r).
   always_comb begin
      ones_nx         = ones + OW'(dut_out);
      shadow_nx       = shadow;
      shadow_nx[~row] = (ones_nx > HALF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         row             <= 3'd0;
         cnt             <= 8'd0;
         ones            <= '0;
         shadow          <= 8'd0;
         {in1, in2, in3} <= 3'b000;
         busy            <= 1'b0;
         done            <= 1'b0;
         table_out       <= 8'h00;
         match           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy            <= 1'b0;
               {in1, in2, in3} <= 3'b000;
               if (start && !abort) begin
                  state  <= SETTLE;
                  row    <= 3'd0;
                  cnt    <= 8'd0;
                  ones   <= '0;
                  shadow <= 8'd0;
                  busy   <= 1'b1;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state           <= IDLE;
                  busy            <= 1'b0;
                  {in1, in2, in3} <= 3'b000;
               end else if (cnt == SET_LAST) begin
                  cnt   <= 8'd0;
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  state           <= IDLE;
                  busy            <= 1'b0;
                  {in1, in2, in3} <= 3'b000;
               end else if (cnt == SMP_LAST) begin
                  cnt    <= 8'd0;
                  ones   <= '0;
                  shadow <= shadow_nx;
                  if (row == 3'd7) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     table_out <= shadow_nx;
                     match     <= (shadow_nx == EXPECTED);
                  end else begin
                     row             <= row + 3'd1;
                     {in1, in2, in3} <= row + 3'd1;
                     state           <= SETTLE;
                  end
               end else begin
                  cnt  <= cnt + 8'd1;
                  ones <= ones_nx;
               end
            end
            DONE: begin
               state           <= IDLE;
               busy            <= 1'b0;
               {in1, in2, in3} <= 3'b000;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a behavioural gate model with optional sample corruption drives the sweeper.
module tb_truth_table_sweeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, dut_out;
   logic       in1, in2, in3, busy, done, match;
   logic [7:0] table_out;

   logic       start_s = 1'b0, dut_out_s;
   logic       in1_s, in2_s, in3_s, busy_s, done_s, match_s;
   logic [7:0] table_out_s;

   int checks = 0;
   int failures = 0;

   logic [7:0] gt = 8'h87;
   int         inj_mode = 0;
   int         cyc = 0;
   logic       flip;

   always #5 clk = ~clk;

   truth_table_sweeper dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
      .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
      .table_out(table_out), .match(match));

   truth_table_sweeper #(.SETTLE_CYCLES(1), .SAMPLES(1), .EXPECTED(8'h87)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0), .dut_out(dut_out_s),
      .in1(in1_s), .in2(in2_s), .in3(in3_s), .busy(busy_s), .done(done_s),
      .table_out(table_out_s), .match(match_s));

   // Cycle index within a default sweep: row = cyc/7, phase = cyc%7, samples at phase 4..6.
   always @(posedge clk) begin
      if (!busy) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always_comb begin
      flip = 1'b0;
      if (inj_mode == 1) flip = (cyc % 7 == 4);
      if (inj_mode == 2) flip = (cyc / 7 == 5) && (cyc % 7 == 4 || cyc % 7 == 5);
      dut_out   = gt[~{in1, in2, in3}] ^ flip;
      dut_out_s = gt[~{in1_s, in2_s, in3_s}];
   end

   // Start a default sweep; lat = cycle (after the start edge) in which done is seen.
   task automatic run_sweep(input int extra_start_at, output int lat);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == extra_start_at || n == extra_start_at + 30) start = 1'b1;
         else start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++;
      if ({in1, in2, in3, busy, done, match, table_out} !== 14'd0) begin
         failures++;
         $display("FAIL reset_state got=%h want=0", {in1, in2, in3, busy, done, match, table_out});
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_gate_87;
      int lat;
      gt = 8'h87; inj_mode = 0;
      run_sweep(0, lat);
      checks++;
      if (lat !== 57) begin failures++; $display("FAIL g87_latency got=%0d want=57", lat); end
      checks++;
      if (table_out !== 8'h87 || match !== 1'b1) begin
         failures++; $display("FAIL g87_table got=%h/%b want=87/1", table_out, match);
      end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL g87_busy_in_done got=%b want=1", busy); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL g87_idle_after got=%b%b want=00", busy, done);
      end
   endtask

   task automatic test_const_gates;
      int lat;
      gt = 8'h00;
      run_sweep(0, lat);
      checks++;
      if (lat !== 57 || table_out !== 8'h00 || match !== 1'b0) begin
         failures++; $display("FAIL const0 got lat=%0d tbl=%h m=%b want 57/00/0", lat, table_out, match);
      end
      gt = 8'hFF;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (table_out !== 8'h00 || busy !== 1'b1) begin
         failures++; $display("FAIL const1_hold got tbl=%h busy=%b want 00/1", table_out, busy);
      end
      lat = -1;
      for (int n = 31; n <= 200; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
      end
      checks++;
      if (lat !== 57 || table_out !== 8'hFF || match !== 1'b0) begin
         failures++; $display("FAIL const1 got lat=%0d tbl=%h m=%b want 57/ff/0", lat, table_out, match);
      end
   endtask

   task automatic test_vote;
      int lat;
      gt = 8'h87; inj_mode = 1;
      run_sweep(0, lat);
      checks++;
      if (table_out !== 8'h87 || match !== 1'b1) begin
         failures++; $display("FAIL vote_one_bad got=%h/%b want=87/1", table_out, match);
      end
      inj_mode = 2;
      run_sweep(0, lat);
      checks++;
      if (table_out !== 8'h83 || match !== 1'b0) begin
         failures++; $display("FAIL vote_two_bad got=%h/%b want=83/0", table_out, match);
      end
      inj_mode = 0;
   endtask

   task automatic test_abort;
      int lat;
      bit seen_done;
      gt = 8'h87;
      run_sweep(0, lat);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 26; n++) begin
         @(negedge clk);
         start = (n == 10);
      end
      start = 1'b0;
      checks++;
      if ({in1, in2, in3} !== 3'b011) begin
         failures++; $display("FAIL abort_row got=%b want=011", {in1, in2, in3});
      end
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {in1, in2, in3} !== 3'b000) begin
         failures++; $display("FAIL abort_idle got busy=%b done=%b in=%b want 0/0/000",
                              busy, done, {in1, in2, in3});
      end
      seen_done = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      checks++;
      if (seen_done || table_out !== 8'h87 || match !== 1'b1) begin
         failures++; $display("FAIL abort_hold got act=%b tbl=%h m=%b want 0/87/1", seen_done, table_out, match);
      end
      run_sweep(5, lat);
      checks++;
      if (lat !== 57) begin failures++; $display("FAIL busy_start_latency got=%0d want=57", lat); end
   endtask

   task automatic test_reset_mid;
      int lat;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (36) @(negedge clk);
      checks++;
      if ({in1, in2, in3} !== 3'b101) begin
         failures++; $display("FAIL rst_row got=%b want=101", {in1, in2, in3});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in1, in2, in3, busy, done, match, table_out} !== 14'd0) begin
         failures++; $display("FAIL async_reset got=%h want=0", {in1, in2, in3, busy, done, match, table_out});
      end
      @(negedge clk) rst_n = 1'b1;
      run_sweep(0, lat);
      checks++;
      if (lat !== 57 || table_out !== 8'h87 || match !== 1'b1) begin
         failures++; $display("FAIL post_reset got lat=%0d tbl=%h m=%b want 57/87/1", lat, table_out, match);
      end
   endtask

   task automatic test_small;
      int lat;
      @(negedge clk) start_s = 1'b1;
      @(posedge clk);
      #1 start_s = 1'b0;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done_s) begin lat = n; break; end
      end
      checks++;
      if (lat !== 17 || table_out_s !== 8'h87 || match_s !== 1'b1) begin
         failures++; $display("FAIL small_cfg got lat=%0d tbl=%h m=%b want 17/87/1", lat, table_out_s, match_s);
      end
   endtask

   initial begin
      test_reset;
      test_gate_87;
      test_const_gates;
      test_vote;
      test_abort;
      test_reset_mid;
      test_small;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
